// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: stall/flush sequencer bus between stall_ctrl and the pipeline.
// Ports: stage stall requests, EX mispredict + target, IF redirect ack (to controller);
//        stall_state, discard, redirect_vld/redirect_pc, perf counters (from controller).
interface stall_ctrl_if #(
  parameter int STALL_W = 6,
  parameter int ADDR_W  = 32,
  parameter int PERF_W  = 32
);
  logic               req_if;
  logic               req_id;
  logic               req_ex;
  logic               req_mem;
  logic               mispredict;
  logic [ADDR_W-1:0]  target_pc;
  logic               redirect_ack;
  logic [STALL_W-1:0] stall_state;
  logic               discard;
  logic               redirect_vld;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [PERF_W-1:0]  perf_stall;
  logic [PERF_W-1:0]  perf_flush;

  // controller side
  modport master (
    input  req_if, req_id, req_ex, req_mem, mispredict, target_pc, redirect_ack,
    output stall_state, discard, redirect_vld, redirect_pc, perf_stall, perf_flush
  );

  // pipeline side
  modport slave (
    output req_if, req_id, req_ex, req_mem, mispredict, target_pc, redirect_ack,
    input  stall_state, discard, redirect_vld, redirect_pc, perf_stall, perf_flush
  );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: merges stage stall requests into one stall vector and turns EX mispredicts
// into a discard pulse plus a held PC redirect. Ports: clk, rst (async active-high), bus (stall_ctrl_if.master).
// Optional feature macro STALL_PERF_EN: saturating stall-cycle and flush counters; otherwise tied to 0.
module stall_ctrl #(
  parameter int STALL_W = 6,
  parameter int ADDR_W  = 32,
  parameter int PERF_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  stall_ctrl_if.master bus
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_FLUSH_PEND = 2'd1;
  localparam logic [1:0] ST_REDIRECT   = 2'd2;

  // Stall patterns: a stage stalls itself and everything upstream of it.
  localparam logic [STALL_W-1:0] MASK_MEM = STALL_W'(5'b11111);
  localparam logic [STALL_W-1:0] MASK_EX  = STALL_W'(4'b1111);
  localparam logic [STALL_W-1:0] MASK_ID  = STALL_W'(3'b111);
  localparam logic [STALL_W-1:0] MASK_IF  = STALL_W'(2'b11);

  logic [1:0]         state;
  logic               ex_hold;
  logic               accept_run;
  logic               release_pend;
  logic               discard_c;
  logic [STALL_W-1:0] stall_c;
  logic               redirect_vld_q;
  logic [ADDR_W-1:0]  redirect_pc_q;

  // EX only holds for its own or a downstream request; ID/IF requests never reach bit 3,
  // so the discard decision below has no loop through the masked requests.
  assign ex_hold      = bus.req_mem | bus.req_ex;
  assign accept_run   = (state == ST_RUN) && bus.mispredict && !ex_hold;
  assign release_pend = (state == ST_FLUSH_PEND) && !ex_hold;
  assign discard_c    = accept_run || release_pend || (state == ST_REDIRECT);

  always_comb begin
    stall_c = '0;
    if (bus.req_mem)
      stall_c = MASK_MEM;
    else if (bus.req_ex)
      stall_c = MASK_EX;
    else if (bus.req_id && !discard_c)  // the requesting instruction is being killed
      stall_c = MASK_ID;
    else if (bus.req_if && !discard_c)
      stall_c = MASK_IF;
    // Keep PC/IF frozen until IF takes the redirect; the ack cycle releases PC so it can load it.
    if ((state == ST_REDIRECT) && !bus.redirect_ack)
      stall_c[1:0] = 2'b11;
  end

  assign bus.stall_state  = stall_c;
  assign bus.discard      = discard_c;
  assign bus.redirect_vld = redirect_vld_q;
  assign bus.redirect_pc  = redirect_pc_q;

  // redirect_pc doubles as the pending-target store while in FLUSH_PEND; redirect_vld qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RUN;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.mispredict) begin
            redirect_pc_q <= bus.target_pc;
            if (!ex_hold) begin
              redirect_vld_q <= 1'b1;
              state          <= ST_REDIRECT;
            end else begin
              state          <= ST_FLUSH_PEND;
            end
          end
        end
        ST_FLUSH_PEND: begin
          // EX is frozen on the same instruction, so a repeated mispredict is not re-latched.
          if (!ex_hold) begin
            redirect_vld_q <= 1'b1;
            state          <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (bus.redirect_ack) begin
            redirect_vld_q <= 1'b0;
            state          <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef STALL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if ((stall_c != '0) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + PERF_ONE;
      // Count only the discard that enters REDIRECT: one per mispredict.
      if (discard_c && (state != ST_REDIRECT) && (perf_flush_q != '1))
        perf_flush_q <= perf_flush_q + PERF_ONE;
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
`else
  assign bus.perf_stall = '0;
  assign bus.perf_flush = '0;
`endif

  // EX carries a bubble during REDIRECT, so no mispredict can arrive there.
  assert property (@(posedge clk) disable iff (rst) !((state == ST_REDIRECT) && bus.mispredict));

endmodule
